// File: rtl/md_unit_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 op codes, FSM state encoding and small op-decode helpers.
package md_unit_sequencer_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_unit_sequencer_if.sv
// EX-stage request/response bundle for the multiply/divide sequencer.
// master = EX stage, slave = sequencer.
interface md_unit_sequencer_if
    import md_unit_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            req_valid;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            flush;
    logic            md_alu_stall;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_result;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, flush,
        input  md_alu_stall, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, flush,
        output md_alu_stall, rsp_valid, rsp_result
    );
endinterface

// File: rtl/md_unit_sequencer_div_special.sv
// Detects divide-by-zero and signed overflow and produces the
// architectural result for those cases without running the divider.
module md_div_special
    import md_unit_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sgn,
    input  logic            rem,
    output logic            hit,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] min_neg;
    logic            div0;
    logic            ovf;

    assign min_neg = {1'b1, {(XLEN-1){1'b0}}};
    assign div0    = (b == '0);
    assign ovf     = sgn & (a == min_neg) & (b == '1);
    assign hit     = div0 | ovf;

    // Select the fixed result: x/0 = all ones, x%0 = x, MIN/-1 = MIN, MIN%-1 = 0
    always_comb begin
        result = '0;
        if (div0) begin
            result = rem ? a : '1;
        end else if (ovf) begin
            result = rem ? '0 : a;
        end
    end
endmodule

// File: rtl/md_unit_sequencer.sv
// Sequences the EX-stage multiplier and iterative divider for RV32M ops,
// stalling EX until one result is returned; reuses the last quot/rem pair.
module md_unit_sequencer
    import md_unit_sequencer_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int FUSE_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    md_unit_sequencer_if.slave ex,
    output logic               mul_start,
    output logic [1:0]         mul_op,
    input  logic               mul_done,
    input  logic [XLEN-1:0]    mul_result,
    output logic               div_start,
    output logic               div_signed,
    output logic               div_abort,
    input  logic               div_done,
    input  logic [XLEN-1:0]    div_quot,
    input  logic [XLEN-1:0]    div_rem,
    output logic [XLEN-1:0]    op_a,
    output logic [XLEN-1:0]    op_b
);
    md_state_e       state;
    md_state_e       state_nx;

    logic            accept;
    logic            launch_mul;
    logic            launch_div;
    logic            fast_done;
    logic            mul_take;
    logic            div_take;

    logic            req_sgn;
    logic            req_rem;
    logic            spec_hit;
    logic            cache_hit;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] fast_res;
    logic            rem_q;

    logic            cache_valid;
    logic            cache_sgn;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic [XLEN-1:0] cache_quot;
    logic [XLEN-1:0] cache_rem;

    assign req_sgn  = op_is_signed(ex.req_op);
    assign req_rem  = op_is_rem(ex.req_op);
    assign accept   = (state == S_IDLE) & ex.req_valid & ~ex.flush;
    assign mul_take = (state == S_MUL_WAIT) & mul_done & ~ex.flush;
    assign div_take = (state == S_DIV_WAIT) & div_done & ~ex.flush;

    assign cache_hit = (FUSE_EN != 0) & cache_valid
                     & (cache_a == ex.req_rs1)
                     & (cache_b == ex.req_rs2)
                     & (cache_sgn == req_sgn);

    assign fast_res = spec_hit ? spec_res
                    : (req_rem ? cache_rem : cache_quot);

    md_div_special #(.XLEN(XLEN)) u_special (
        .a      (ex.req_rs1),
        .b      (ex.req_rs2),
        .sgn    (req_sgn),
        .rem    (req_rem),
        .hit    (spec_hit),
        .result (spec_res)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, stall/response strobes and unit launch decisions
    always_comb begin
        state_nx        = state;
        ex.md_alu_stall = 1'b0;
        ex.rsp_valid    = 1'b0;
        div_abort       = 1'b0;
        launch_mul      = 1'b0;
        launch_div      = 1'b0;
        fast_done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    ex.md_alu_stall = 1'b1;
                    if (!op_is_div(ex.req_op)) begin
                        launch_mul = 1'b1;
                        state_nx   = S_MUL_WAIT;
                    end else if (spec_hit || cache_hit) begin
                        fast_done = 1'b1;
                        state_nx  = S_DONE;
                    end else begin
                        launch_div = 1'b1;
                        state_nx   = S_DIV_WAIT;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (ex.flush) begin
                    state_nx = S_IDLE;
                end else begin
                    ex.md_alu_stall = 1'b1;
                    if (mul_done) state_nx = S_DONE;
                end
            end
            S_DIV_WAIT: begin
                if (ex.flush) begin
                    div_abort = 1'b1;
                    state_nx  = S_IDLE;
                end else begin
                    ex.md_alu_stall = 1'b1;
                    if (div_done) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                ex.rsp_valid = ~ex.flush;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch, unit start pulses and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_start     <= 1'b0;
            div_start     <= 1'b0;
            mul_op        <= '0;
            div_signed    <= 1'b0;
            rem_q         <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            ex.rsp_result <= '0;
        end else begin
            mul_start <= launch_mul;
            div_start <= launch_div;
            if (accept) begin
                mul_op     <= ex.req_op[1:0];
                div_signed <= req_sgn;
                rem_q      <= req_rem;
                op_a       <= ex.req_rs1;
                op_b       <= ex.req_rs2;
            end
            if (fast_done) begin
                ex.rsp_result <= fast_res;
            end else if (mul_take) begin
                ex.rsp_result <= mul_result;
            end else if (div_take) begin
                ex.rsp_result <= rem_q ? div_rem : div_quot;
            end
        end
    end

    // Quotient/remainder reuse cache, refreshed by every completed divide
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_sgn   <= 1'b0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_quot  <= '0;
            cache_rem   <= '0;
        end else if (div_take) begin
            cache_valid <= 1'b1;
            cache_sgn   <= div_signed;
            cache_a     <= op_a;
            cache_b     <= op_b;
            cache_quot  <= div_quot;
            cache_rem   <= div_rem;
        end
    end
endmodule

// File: tb/tb_md_unit_sequencer.sv
// Self-checking bench for md_unit_sequencer: directed vector table,
// multi-cycle corner sequences and randomized ops against a reference model.
module tb_md_unit_sequencer;
    import md_unit_sequencer_pkg::*;

    localparam int MG = 2;
    localparam int DG = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mul_start, div_start, div_signed, div_abort;
    logic [1:0]  mul_op;
    logic        mul_done = 1'b0;
    logic        div_done = 1'b0;
    logic [31:0] mul_result = '0;
    logic [31:0] div_quot = '0;
    logic [31:0] div_rem = '0;
    logic [31:0] op_a, op_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    md_unit_sequencer_if bus ();

    md_unit_sequencer #(.XLEN(32), .FUSE_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex         (bus),
        .mul_start  (mul_start),
        .mul_op     (mul_op),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_abort  (div_abort),
        .div_done   (div_done),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .op_a       (op_a),
        .op_b       (op_b)
    );

    // RV32M result of one op, straight from the ISA rules
    function automatic logic [31:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a, b);
        logic [63:0] p;
        int sa, sb;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: p = {32'b0, a} * {32'b0, b};
            3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'd2: p = {{32{a[31]}}, a} * {32'b0, b};
            3'd3: p = {32'b0, a} * {32'b0, b};
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
        return (op == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier model: done pulse MG cycles after the start cycle
    int m_cnt = 0;
    always @(posedge clk) begin
        logic st, rs;
        logic [1:0] mo;
        logic [31:0] a, b;
        st = mul_start; rs = reset; mo = mul_op; a = op_a; b = op_b;
        #1;
        mul_done = 1'b0;
        if (rs) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) mul_done = 1'b1;
            end
            if (st) begin
                m_cnt = MG - 1;
                mul_result = ref_md({1'b0, mo}, a, b);
            end
        end
    end

    // Divider model: done pulse DG cycles after start, killed by abort
    int d_cnt = 0;
    always @(posedge clk) begin
        logic st, rs, ab, sg;
        logic [31:0] a, b;
        st = div_start; rs = reset; ab = div_abort; sg = div_signed;
        a = op_a; b = op_b;
        #1;
        div_done = 1'b0;
        if (rs) begin
            d_cnt = 0;
        end else begin
            if (d_cnt > 0) begin
                d_cnt--;
                if (d_cnt == 0) div_done = 1'b1;
            end
            if (st) begin
                d_cnt = DG - 1;
                div_quot = ref_md(sg ? MD_OP_DIV : MD_OP_DIVU, a, b);
                div_rem  = ref_md(sg ? MD_OP_REM : MD_OP_REMU, a, b);
            end
            if (ab) d_cnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one op; fcyc>0 raises flush in that cycle (0 = accept cycle)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                          input int fcyc, output logic [31:0] res,
                          output int nrsp, nstall, ndiv, nmul, nab,
                          output bit tmo);
        res = '0; nrsp = 0; nstall = 0; ndiv = 0; nmul = 0; nab = 0;
        tmo = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = op;
        bus.req_rs1 = a; bus.req_rs2 = b; bus.flush = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.md_alu_stall) nstall++;
            if (bus.rsp_valid) begin nrsp++; res = bus.rsp_result; end
            if (div_start) ndiv++;
            if (mul_start) nmul++;
            if (div_abort) nab++;
            if (!bus.md_alu_stall) begin tmo = 1'b0; break; end
            @(posedge clk); #1;
            bus.flush = (c + 1 == fcyc);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        if (bus.rsp_valid) nrsp++;
        if (div_start) ndiv++;
        if (mul_start) nmul++;
        repeat (3) @(posedge clk);
    endtask

    // Reference cache: last divide the divider actually completed
    bit          cv = 0;
    bit          cs = 0;
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;

    task automatic exec(input logic [2:0] op, input logic [31:0] a, b,
                        input bit fl);
        logic [31:0] res;
        int nrsp, nst, ndv, nml, nab, s, fc;
        bit tmo, is_mul, sg, spec, hit, run_div;
        is_mul  = !op[2];
        sg      = !op[0];
        spec    = (b == 0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit     = cv && ca == a && cb == b && cs == sg;
        run_div = !is_mul && !spec && !hit;
        s  = is_mul ? MG + 2 : run_div ? DG + 2 : 1;
        fc = fl ? $urandom_range(1, s) : 0;
        run_op(op, a, b, fc, res, nrsp, nst, ndv, nml, nab, tmo);
        chk("rnd_timeout", 32'(tmo), 32'd0);
        chk("rnd_stall", nst, fl ? fc : s);
        chk("rnd_rsp", nrsp, fl ? 0 : 1);
        chk("rnd_div_start", ndv, 32'(run_div));
        chk("rnd_mul_start", nml, 32'(is_mul));
        chk("rnd_abort", nab, 32'(run_div && fl && fc <= s - 1));
        if (!fl) chk("rnd_result", res, ref_md(op, a, b));
        if (run_div && (!fl || fc == s)) begin
            cv = 1; ca = a; cb = b; cs = sg;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          stall;
        int          ndiv;
    } vec_t;

    vec_t tv[13];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, pa, pb;
        int nrsp, nst, ndv, nml, nab;
        bit tmo;

        tv[0]  = '{MD_OP_MUL,    32'd7,        32'd6,        32'd42,       4,  0};
        tv[1]  = '{MD_OP_DIV,    32'h64,       32'h0,        32'hFFFF_FFFF, 1, 0};
        tv[2]  = '{MD_OP_REMU,   32'd5,        32'h0,        32'd5,        1,  0};
        tv[3]  = '{MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0};
        tv[4]  = '{MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,      1,  0};
        tv[5]  = '{MD_OP_DIV,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 34, 1};
        tv[6]  = '{MD_OP_REM,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 1, 0};
        tv[7]  = '{MD_OP_REMU,   32'hFFFF_FFF9, 32'd2,       32'd1,        34, 1};
        tv[8]  = '{MD_OP_DIVU,   32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC, 1, 0};
        tv[9]  = '{MD_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,      4,  0};
        tv[10] = '{MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 0};
        tv[11] = '{MD_OP_MULHSU, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 4, 0};
        tv[12] = '{MD_OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,      34, 1};

        bus.req_valid = 1'b0; bus.req_op = '0;
        bus.req_rs1 = '0; bus.req_rs2 = '0; bus.flush = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {24'b0, bus.md_alu_stall, bus.rsp_valid, mul_start,
            div_start, div_abort, div_signed, mul_op}, 32'h0);
        chk("reset_result", bus.rsp_result, 32'h0);
        chk("reset_op_a", op_a, 32'h0);
        chk("reset_op_b", op_b, 32'h0);

        for (int i = 0; i < 13; i++) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, 0, res, nrsp, nst, ndv, nml, nab, tmo);
            chk($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
            chk($sformatf("vec%0d_result", i), res, tv[i].res);
            chk($sformatf("vec%0d_rsp", i), nrsp, 32'd1);
            chk($sformatf("vec%0d_stall", i), nst, tv[i].stall);
            chk($sformatf("vec%0d_div_start", i), ndv, tv[i].ndiv);
            chk($sformatf("vec%0d_mul_start", i), nml, 32'(tv[i].op[2] == 1'b0));
        end

        run_op(MD_OP_DIV, 32'd100, 32'd7, 10, res, nrsp, nst, ndv, nml, nab, tmo);
        chk("flush_rsp", nrsp, 32'd0);
        chk("flush_abort", nab, 32'd1);
        chk("flush_stall", nst, 32'd10);
        chk("flush_div_start", ndv, 32'd1);
        run_op(MD_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, nrsp, nst, ndv, nml, nab, tmo);
        chk("flush_cache_kept_res", res, 32'h0);
        chk("flush_cache_kept_div", ndv, 32'd0);
        chk("flush_cache_kept_stall", nst, 32'd1);
        run_op(MD_OP_DIV, 32'd100, 32'd7, 0, res, nrsp, nst, ndv, nml, nab, tmo);
        chk("after_flush_res", res, 32'd14);
        chk("after_flush_div", ndv, 32'd1);
        chk("after_flush_stall", nst, 32'd34);

        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = MD_OP_MUL;
        bus.req_rs1 = 32'd3; bus.req_rs2 = 32'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_done_seen", 32'(mul_done), 32'd1);
        chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", {24'b0, bus.md_alu_stall, bus.rsp_valid, mul_start,
            div_start, div_abort, div_signed, mul_op}, 32'h0);
        chk("rst_mid_result", bus.rsp_result, 32'h0);
        chk("rst_mid_ops", {op_a[15:0], op_b[15:0]}, 32'h0);
        repeat (3) @(posedge clk);
        run_op(MD_OP_REM, 32'd100, 32'd7, 0, res, nrsp, nst, ndv, nml, nab, tmo);
        chk("rst_cache_clear_div", ndv, 32'd1);
        chk("rst_cache_clear_res", res, 32'd2);

        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        cv = 0;
        pa = '0; pb = '0;
        for (int i = 0; i < 120; i++) begin
            logic [2:0] op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            if (i > 0 && $urandom_range(0, 2) == 0) begin
                a = pa; b = pb;
            end else begin
                a = pick(); b = pick();
            end
            pa = a; pb = b;
            exec(op, a, b, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
